// File: rtl/step_input_conditioner.sv
`default_nettype none
// ============================================================================
// step_input_conditioner: syncs, debounces and auto-repeats a push-button
// into a one-cycle step enable; syncs and double-samples slide switches.
// Rev 1.0
// ============================================================================
module step_input_conditioner #(
  parameter int SW_WIDTH         = 4,
  parameter int DEBOUNCE_CYCLES  = 1_000_000,
  parameter int HOLD_CYCLES      = 50_000_000,
  parameter int REPEAT_CYCLES    = 10_000_000,
  parameter int SW_SAMPLE_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_raw,
  input  logic [SW_WIDTH-1:0] sw_raw,
  output logic                btn_level,
  output logic                step_pulse,
  output logic [SW_WIDTH-1:0] sw_level,
  output logic                sw_changed,
  output logic [7:0]          step_count
);

  localparam int DEB_W = (DEBOUNCE_CYCLES  > 2) ? $clog2(DEBOUNCE_CYCLES)  : 1;
  localparam int HLD_W = (HOLD_CYCLES      > 2) ? $clog2(HOLD_CYCLES)      : 1;
  localparam int REP_W = (REPEAT_CYCLES    > 2) ? $clog2(REPEAT_CYCLES)    : 1;
  localparam int SMP_W = (SW_SAMPLE_CYCLES > 2) ? $clog2(SW_SAMPLE_CYCLES) : 1;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLD_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SW_SAMPLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  logic                btn_meta_q, btn_meta_d;
  logic                btn_sync_q, btn_sync_d;
  logic [SW_WIDTH-1:0] sw_meta_q, sw_meta_d;
  logic [SW_WIDTH-1:0] sw_sync_q, sw_sync_d;
  logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
  logic                btn_level_q, btn_level_d;
  state_t              state_q, state_d;
  logic [HLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [REP_W-1:0]    rep_cnt_q, rep_cnt_d;
  logic                step_pulse_q, step_pulse_d;
  logic [7:0]          step_count_q, step_count_d;
  logic [SMP_W-1:0]    smp_cnt_q, smp_cnt_d;
  logic [SW_WIDTH-1:0] sw_sample_q, sw_sample_d;
  logic [SW_WIDTH-1:0] sw_level_q, sw_level_d;
  logic                sw_changed_q, sw_changed_d;
  logic                sw_tick;
  logic [SW_WIDTH-1:0] sw_agree;

  // Two-flop synchronizers and button debounce counter
  always_comb begin
    btn_meta_d  = btn_raw;
    btn_sync_d  = btn_meta_q;
    sw_meta_d   = sw_raw;
    sw_sync_d   = sw_meta_q;
    deb_cnt_d   = '0;
    btn_level_d = btn_level_q;
    if (btn_sync_q != btn_level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        btn_level_d = btn_sync_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  // Step FSM: release always takes priority over a pulse due the same cycle
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    rep_cnt_d    = rep_cnt_q;
    step_pulse_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (btn_level_q) begin
          step_pulse_d = 1'b1;
          hold_cnt_d   = '0;
          state_d      = ST_HELD;
        end
      end
      ST_HELD: begin
        if (!btn_level_q) begin
          state_d = ST_IDLE;
        end else if (hold_cnt_q == HLD_LAST) begin
          step_pulse_d = 1'b1;
          rep_cnt_d    = '0;
          state_d      = ST_REPEAT;
        end else begin
          hold_cnt_d = hold_cnt_q + HLD_W'(1);
        end
      end
      ST_REPEAT: begin
        if (!btn_level_q) begin
          state_d = ST_IDLE;
        end else if (rep_cnt_q == REP_LAST) begin
          step_pulse_d = 1'b1;
          rep_cnt_d    = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    step_count_d = step_count_q + {7'd0, step_pulse_d};
  end

  // A switch bit moves only when the new sample matches the previous one
  always_comb begin
    sw_tick      = (smp_cnt_q == SMP_LAST);
    smp_cnt_d    = sw_tick ? '0 : smp_cnt_q + SMP_W'(1);
    sw_agree     = ~(sw_sync_q ^ sw_sample_q);
    sw_sample_d  = sw_sample_q;
    sw_level_d   = sw_level_q;
    sw_changed_d = 1'b0;
    if (sw_tick) begin
      sw_sample_d  = sw_sync_q;
      sw_level_d   = (sw_level_q & ~sw_agree) | (sw_sync_q & sw_agree);
      sw_changed_d = (sw_level_d != sw_level_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta_q   <= 1'b0;
      btn_sync_q   <= 1'b0;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      deb_cnt_q    <= '0;
      btn_level_q  <= 1'b0;
      state_q      <= ST_IDLE;
      hold_cnt_q   <= '0;
      rep_cnt_q    <= '0;
      step_pulse_q <= 1'b0;
      step_count_q <= '0;
      smp_cnt_q    <= '0;
      sw_sample_q  <= '0;
      sw_level_q   <= '0;
      sw_changed_q <= 1'b0;
    end else begin
      btn_meta_q   <= btn_meta_d;
      btn_sync_q   <= btn_sync_d;
      sw_meta_q    <= sw_meta_d;
      sw_sync_q    <= sw_sync_d;
      deb_cnt_q    <= deb_cnt_d;
      btn_level_q  <= btn_level_d;
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      rep_cnt_q    <= rep_cnt_d;
      step_pulse_q <= step_pulse_d;
      step_count_q <= step_count_d;
      smp_cnt_q    <= smp_cnt_d;
      sw_sample_q  <= sw_sample_d;
      sw_level_q   <= sw_level_d;
      sw_changed_q <= sw_changed_d;
    end
  end

  assign btn_level  = btn_level_q;
  assign step_pulse = step_pulse_q;
  assign sw_level   = sw_level_q;
  assign sw_changed = sw_changed_q;
  assign step_count = step_count_q;

endmodule
`default_nettype wire

// File: tb/tb_step_input_conditioner.sv
`default_nettype none
// ============================================================================
// tb_step_input_conditioner: scoreboard bench with a timing-rule reference
// model for the step/switch input conditioner.  Rev 1.0
// ============================================================================
module tb_step_input_conditioner;

  localparam int SW   = 4;
  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;
  localparam int SMP  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          btn_raw = 1'b0;
  logic [SW-1:0] sw_raw = '0;
  logic          btn_level;
  logic          step_pulse;
  logic [SW-1:0] sw_level;
  logic          sw_changed;
  logic [7:0]    step_count;

  step_input_conditioner #(
    .SW_WIDTH(SW), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP), .SW_SAMPLE_CYCLES(SMP)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .btn_level(btn_level), .step_pulse(step_pulse), .sw_level(sw_level),
    .sw_changed(sw_changed), .step_count(step_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          lvl;
    logic          pulse;
    logic [SW-1:0] sw;
    logic          chg;
    logic [7:0]    cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   pulse_seen = 0;
  int   chg_seen   = 0;
  int   m_pulses   = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: button level flips once the last DEB synchronized samples
  // all disagree with it; pulses fall at press age 0, HOLD, HOLD+k*REP.
  initial begin : model
    logic          b1, b2, lvl, act, pulse, chg;
    logic [SW-1:0] s1, s2, smp, swl, nxt;
    logic          hist[$];
    int            age, k;
    logic [7:0]    cnt;
    bit            all_diff;
    b1 = 0; b2 = 0; s1 = '0; s2 = '0; lvl = 0; act = 0; age = 0; k = 0;
    cnt = '0; smp = '0; swl = '0;
    forever begin
      @(posedge clk);
      pulse = 0;
      chg   = 0;
      if (rst) begin
        b1 = 0; b2 = 0; s1 = '0; s2 = '0; lvl = 0; act = 0; age = 0; k = 0;
        cnt = '0; smp = '0; swl = '0;
        hist.delete();
      end else begin
        hist.push_back(b2);
        if (hist.size() > DEB) void'(hist.pop_front());
        all_diff = (hist.size() == DEB);
        foreach (hist[i]) if (hist[i] == lvl) all_diff = 0;
        if (!act) begin
          if (lvl) begin pulse = 1; act = 1; age = 0; end
        end else if (!lvl) begin
          act = 0;
        end else begin
          age++;
          pulse = (age == HOLD) || (age > HOLD && ((age - HOLD) % REP) == 0);
        end
        if (all_diff) lvl = ~lvl;
        if (pulse) begin cnt = cnt + 8'd1; m_pulses++; end
        k++;
        if (k % SMP == 0) begin
          for (int i = 0; i < SW; i++) nxt[i] = (s2[i] == smp[i]) ? s2[i] : swl[i];
          chg = (nxt != swl);
          swl = nxt;
          smp = s2;
        end
        b2 = b1; b1 = btn_raw;
        s2 = s1; s1 = sw_raw;
      end
      exp_q.push_back('{lvl: lvl, pulse: pulse, sw: swl, chg: chg, cnt: cnt});
    end
  end

  initial begin : monitor
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (step_pulse) pulse_seen++;
      if (sw_changed) chg_seen++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard: no expected entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (btn_level !== e.lvl || step_pulse !== e.pulse || sw_level !== e.sw ||
            sw_changed !== e.chg || step_count !== e.cnt) begin
          n_fail++;
          $display("FAIL outputs @%0t: got lvl=%b pulse=%b sw=%h chg=%b cnt=%0d, expected lvl=%b pulse=%b sw=%h chg=%b cnt=%0d",
                   $time, btn_level, step_pulse, sw_level, sw_changed, step_count,
                   e.lvl, e.pulse, e.sw, e.chg, e.cnt);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    int p0, c0, mp0;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(2);
    // Reset state
    check("rst_btn_level", btn_level, 0);
    check("rst_step_pulse", step_pulse, 0);
    check("rst_sw_level", sw_level, 0);
    check("rst_step_count", step_count, 0);

    // Clean press: level rises 6 cycles after the edge, one pulse
    p0 = pulse_seen;
    btn_raw = 1'b1;
    wait_cycles(5);
    check("press_lvl_before", btn_level, 0);
    wait_cycles(1);
    check("press_lvl_at6", btn_level, 1);
    wait_cycles(4);
    btn_raw = 1'b0;
    wait_cycles(6);
    check("release_lvl_at6", btn_level, 0);
    wait_cycles(4);
    check("press_pulses", pulse_seen - p0, 1);
    check("press_count", step_count, 1);

    // Bounce shorter than the debounce window
    p0 = pulse_seen;
    for (int i = 0; i < 20; i++) begin
      btn_raw = ~btn_raw;
      wait_cycles(2);
    end
    btn_raw = 1'b0;
    wait_cycles(10);
    check("bounce_lvl", btn_level, 0);
    check("bounce_pulses", pulse_seen - p0, 0);

    // Long hold with auto-repeat
    p0 = pulse_seen; mp0 = m_pulses;
    btn_raw = 1'b1;
    wait_cycles(100);
    btn_raw = 1'b0;
    wait_cycles(12);
    check("hold_pulses_vs_model", pulse_seen - p0, m_pulses - mp0);
    check("hold_pulses", pulse_seen - p0, 11);

    // Release lands exactly when a repeat pulse is due
    p0 = pulse_seen;
    btn_raw = 1'b1;
    wait_cycles(36);
    btn_raw = 1'b0;
    wait_cycles(12);
    check("race_pulses", pulse_seen - p0, 3);

    // Switch change and single-cycle glitch
    c0 = chg_seen;
    sw_raw = 4'b0101;
    wait_cycles(10);
    check("sw_level_new", sw_level, 5);
    check("sw_changed_once", chg_seen - c0, 1);
    c0 = chg_seen;
    sw_raw = 4'b1101;
    wait_cycles(1);
    sw_raw = 4'b0101;
    wait_cycles(12);
    check("sw_glitch_level", sw_level, 5);
    check("sw_glitch_chg", chg_seen - c0, 0);

    // Reset while auto-repeating, button still held
    btn_raw = 1'b1;
    wait_cycles(40);
    rst = 1'b1;
    wait_cycles(2);
    check("midrst_lvl", btn_level, 0);
    check("midrst_count", step_count, 0);
    check("midrst_sw", sw_level, 0);
    rst = 1'b0;
    wait_cycles(6);
    check("postrst_lvl", btn_level, 1);
    check("postrst_count0", step_count, 0);
    wait_cycles(1);
    check("postrst_pulse", step_pulse, 1);
    check("postrst_count1", step_count, 1);
    btn_raw = 1'b0;
    wait_cycles(10);

    // Randomized mix of bounces, holds, switch changes and resets
    for (int seg = 0; seg < 60; seg++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind < 3) begin
        repeat ($urandom_range(3, 15)) begin
          btn_raw = ~btn_raw;
          wait_cycles(int'($urandom_range(1, 5)));
        end
      end else if (kind < 7) begin
        btn_raw = 1'($urandom_range(0, 1));
        sw_raw  = SW'($urandom);
        wait_cycles(int'($urandom_range(5, 70)));
      end else if (kind < 9) begin
        sw_raw = sw_raw ^ SW'(1 << $urandom_range(0, SW - 1));
        wait_cycles(1);
        sw_raw = sw_raw ^ SW'($urandom_range(0, 1) << $urandom_range(0, SW - 1));
        wait_cycles(int'($urandom_range(3, 12)));
      end else begin
        rst = 1'b1;
        wait_cycles(int'($urandom_range(1, 2)));
        rst = 1'b0;
        wait_cycles(int'($urandom_range(2, 10)));
      end
    end
    btn_raw = 1'b0;
    wait_cycles(20);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
